// File: rtl/time_set_ctrl_if.sv
// Front-panel set interface for time_set_ctrl.
//
// Groups the three debounced keys, the live BCD time from the hour/minute
// counters, and the set controls driven back to those counters.
//   master : panel/counter side (drives keys and current time, sees set controls)
//   slave  : time_set_ctrl (consumes keys and current time, drives set controls)
//
// Signals:
//   key_mode, key_up, key_down : debounced key levels, asynchronous to clk
//   cur_hour1/2, cur_min1/2    : live BCD tens/ones of hour and minute
//   set_hour, set_min          : load-enable for the hour/minute counter
//   set_num1, set_num2         : edited BCD value, tens/ones
//   edit_field                 : 00 idle, 01 hour, 10 minute
interface time_set_ctrl_if;
  logic       key_mode;
  logic       key_up;
  logic       key_down;
  logic [3:0] cur_hour1;
  logic [3:0] cur_hour2;
  logic [3:0] cur_min1;
  logic [3:0] cur_min2;
  logic       set_hour;
  logic       set_min;
  logic [3:0] set_num1;
  logic [3:0] set_num2;
  logic [1:0] edit_field;

  modport master (
    output key_mode,
    output key_up,
    output key_down,
    output cur_hour1,
    output cur_hour2,
    output cur_min1,
    output cur_min2,
    input  set_hour,
    input  set_min,
    input  set_num1,
    input  set_num2,
    input  edit_field
  );

  modport slave (
    input  key_mode,
    input  key_up,
    input  key_down,
    input  cur_hour1,
    input  cur_hour2,
    input  cur_min1,
    input  cur_min2,
    output set_hour,
    output set_min,
    output set_num1,
    output set_num2,
    output edit_field
  );
endinterface

// File: rtl/time_set_ctrl.sv
// Time-setting controller for the PengTimer front panel.
//
// A mode press captures the live hour into an edit register and takes over the
// hour counter (set_hour); a second mode press does the same for the minute
// counter (set_min); a third returns both counters to free-running. Up/down
// presses step the edited field with BCD wrap-around. An edit state with no
// key activity for TIMEOUT_CYCLES cycles drops back to idle.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : time_set_ctrl_if.slave (keys, live time in; set controls out)
//
// All outputs come from flops or a direct decode of the state register.
module time_set_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input logic            clk,
  input logic            rst,
  time_set_ctrl_if.slave bus
);

  localparam int unsigned     CntW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  // Field limits, both in BCD (for wrap) and binary (for capture validation).
  localparam logic [7:0] HourMaxBcd = 8'h23;
  localparam logic [7:0] MinMaxBcd  = 8'h59;
  localparam logic [7:0] HourMaxBin = 8'd23;
  localparam logic [7:0] MinMaxBin  = 8'd59;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StEditH = 2'b01,
    StEditM = 2'b10
  } state_e;

  // Returns the captured value, or 00 if it is not a legal time for the field.
  function automatic logic [7:0] bcd_capture(input logic [3:0] tens,
                                             input logic [3:0] ones,
                                             input logic [7:0] max_bin);
    logic [7:0] total;
    total = 8'(tens) * 8'd10 + 8'(ones);
    if (tens > 4'd9 || ones > 4'd9 || total > max_bin) begin
      return 8'h00;
    end
    return {tens, ones};
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max_bcd);
    if (val == max_bcd) begin
      return 8'h00;
    end else if (val[3:0] == 4'd9) begin
      return {val[7:4] + 4'd1, 4'd0};
    end
    return {val[7:4], val[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] val, input logic [7:0] max_bcd);
    if (val == 8'h00) begin
      return max_bcd;
    end else if (val[3:0] == 4'd0) begin
      return {val[7:4] - 4'd1, 4'd9};
    end
    return {val[7:4], val[3:0] - 4'd1};
  endfunction

  // Key front end: bit 0 mode, bit 1 up, bit 2 down.
  logic [2:0] key_raw;
  logic [2:0] s1_q, s2_q, s3_q;
  logic [2:0] press;
  logic       mode_press, up_press, down_press;

  assign key_raw    = {bus.key_down, bus.key_up, bus.key_mode};
  // s1/s2 synchronise, s3 is the previous level; flops reset high so a key
  // held through reset never looks like a fresh press.
  assign press      = s2_q & ~s3_q;
  assign mode_press = press[0];
  assign up_press   = press[1];
  assign down_press = press[2];

  state_e          state_q, state_d;
  logic [7:0]      edit_q, edit_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 3'b111;
      s2_q    <= 3'b111;
      s3_q    <= 3'b111;
      state_q <= StIdle;
      edit_q  <= 8'h00;
      cnt_q   <= '0;
    end else begin
      s1_q    <= key_raw;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      state_q <= state_d;
      edit_q  <= edit_d;
      cnt_q   <= cnt_d;
    end
  end

  logic [7:0] field_max;
  assign field_max = (state_q == StEditH) ? HourMaxBcd : MinMaxBcd;

  always_comb begin
    state_d = state_q;
    edit_d  = edit_q;
    cnt_d   = cnt_q;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (mode_press) begin
          edit_d  = bcd_capture(bus.cur_hour1, bus.cur_hour2, HourMaxBin);
          state_d = StEditH;
        end
      end

      StEditH, StEditM: begin
        if (cnt_q == CntLast) begin
          // Inactivity expiry overrides anything pressed on the same edge.
          state_d = StIdle;
          cnt_d   = '0;
        end else if (mode_press) begin
          cnt_d = '0;
          if (state_q == StEditH) begin
            edit_d  = bcd_capture(bus.cur_min1, bus.cur_min2, MinMaxBin);
            state_d = StEditM;
          end else begin
            state_d = StIdle;
          end
        end else if (up_press || down_press) begin
          // Up+down together is activity but moves nothing.
          cnt_d = '0;
          if (up_press && !down_press) begin
            edit_d = bcd_inc(edit_q, field_max);
          end else if (down_press && !up_press) begin
            edit_d = bcd_dec(edit_q, field_max);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.set_hour   = (state_q == StEditH);
  assign bus.set_min    = (state_q == StEditM);
  assign bus.set_num1   = edit_q[7:4];
  assign bus.set_num2   = edit_q[3:0];
  assign bus.edit_field = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed walk through the set sequence, then random
// key/time/reset traffic, all checked cycle by cycle against a behavioural model
// that keeps the edited time as a plain integer and wraps with modulo arithmetic.
module tb_time_set_ctrl;
  localparam int unsigned Timeout = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  time_set_ctrl_if bus ();

  time_set_ctrl #(
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model. State 0 idle, 1 hour, 2 minute; value is an integer time.
  int m_state = 0;
  int m_val   = 0;
  int m_last  = 0;
  int m_edge  = 0;
  bit hist[3][3];  // per key: [0] sampled 1 edge ago, [1] 2 ago, [2] 3 ago

  function automatic int capture(input int t, input int o, input int lim);
    if (t > 9 || o > 9 || t * 10 + o >= lim) return 0;
    return t * 10 + o;
  endfunction

  task automatic model_step();
    bit p[3];
    bit smp[3];
    int lim;
    m_edge++;
    smp[0] = bus.key_mode;
    smp[1] = bus.key_up;
    smp[2] = bus.key_down;
    if (rst) begin
      m_state = 0;
      m_val   = 0;
      for (int k = 0; k < 3; k++) for (int a = 0; a < 3; a++) hist[k][a] = 1'b1;
      return;
    end
    // A press acts two edges after the first high sample, provided the sample
    // before that was low.
    for (int k = 0; k < 3; k++) begin
      p[k] = hist[k][1] && !hist[k][2];
      hist[k][2] = hist[k][1];
      hist[k][1] = hist[k][0];
      hist[k][0] = smp[k];
    end
    lim = (m_state == 1) ? 24 : 60;
    if (m_state != 0 && m_edge - m_last == int'(Timeout)) begin
      m_state = 0;
    end else if (p[0]) begin
      m_last = m_edge;
      if (m_state == 0) begin
        m_val   = capture(int'(bus.cur_hour1), int'(bus.cur_hour2), 24);
        m_state = 1;
      end else if (m_state == 1) begin
        m_val   = capture(int'(bus.cur_min1), int'(bus.cur_min2), 60);
        m_state = 2;
      end else begin
        m_state = 0;
      end
    end else if (m_state != 0 && (p[1] || p[2])) begin
      m_last = m_edge;
      if (p[1] && !p[2]) m_val = (m_val + 1) % lim;
      else if (p[2] && !p[1]) m_val = (m_val + lim - 1) % lim;
    end
  endtask

  // One clock: model and DUT advance on the edge, outputs compared 1 ns later,
  // then back to the falling edge where stimulus changes.
  task automatic tick();
    logic [7:0] exp_num;
    @(posedge clk);
    model_step();
    #1;
    exp_num = {4'(m_val / 10), 4'(m_val % 10)};
    check("field", {6'b0, bus.edit_field}, 8'(m_state));
    check("set", {6'b0, bus.set_hour, bus.set_min}, {6'b0, m_state == 1, m_state == 2});
    check("num", {bus.set_num1, bus.set_num2}, exp_num);
    @(negedge clk);
  endtask

  task automatic set_keys(input logic [2:0] m);
    bus.key_mode = m[0];
    bus.key_up   = m[1];
    bus.key_down = m[2];
  endtask

  task automatic set_cur(input int h1, input int h2, input int n1, input int n2);
    bus.cur_hour1 = 4'(h1);
    bus.cur_hour2 = 4'(h2);
    bus.cur_min1  = 4'(n1);
    bus.cur_min2  = 4'(n2);
  endtask

  // Two sampled-high edges then three low; the press has acted on return.
  task automatic press(input logic [2:0] m);
    set_keys(m);
    tick();
    tick();
    set_keys(3'b000);
    tick();
    tick();
    tick();
  endtask

  task automatic check_out(input string tag, input logic [1:0] field, input logic [7:0] num);
    check({tag, "_field"}, {6'b0, bus.edit_field}, {6'b0, field});
    check({tag, "_num"}, {bus.set_num1, bus.set_num2}, num);
  endtask

  int          rem[3];
  logic [2:0]  lv;

  initial begin
    rst = 1'b1;
    set_keys(3'b000);
    set_cur(1, 4, 3, 7);
    @(negedge clk);
    tick();
    tick();
    check_out("reset", 2'b00, 8'h00);
    rst = 1'b0;
    tick();

    // Hour edit from 14:37, up x10 wraps 23 -> 00.
    press(3'b001);
    check_out("enter_h", 2'b01, 8'h14);
    for (int i = 0; i < 10; i++) press(3'b010);
    check_out("hour_wrap_up", 2'b01, 8'h00);
    press(3'b100);
    check_out("hour_wrap_dn", 2'b01, 8'h23);
    press(3'b001);
    check_out("enter_m", 2'b10, 8'h37);
    check("enter_m_set", {6'b0, bus.set_hour, bus.set_min}, 8'h01);
    for (int i = 0; i < 38; i++) press(3'b100);
    check_out("min_wrap_dn", 2'b10, 8'h59);
    press(3'b010);
    check_out("min_wrap_up", 2'b10, 8'h00);
    press(3'b001);
    check_out("exit", 2'b00, 8'h00);

    // Capture guard on illegal live times.
    set_cur(2, 7, 6, 1);
    press(3'b001);
    check_out("guard_h", 2'b01, 8'h00);
    press(3'b001);
    check_out("guard_m", 2'b10, 8'h00);
    press(3'b001);

    // Same-cycle presses.
    set_cur(1, 4, 3, 7);
    press(3'b001);
    press(3'b011);
    check_out("mode_up", 2'b10, 8'h37);
    press(3'b110);
    check_out("up_down", 2'b10, 8'h37);

    // Timeout after the up+down activity, then after a fresh entry.
    for (int i = 0; i < 13; i++) tick();
    check_out("to_before", 2'b10, 8'h37);
    tick();
    check_out("to_after", 2'b00, 8'h37);
    press(3'b001);
    for (int i = 0; i < 13; i++) tick();
    check_out("to_h_before", 2'b01, 8'h14);
    tick();
    check_out("to_h_after", 2'b00, 8'h14);

    // Reset mid-edit, then a key held through reset release.
    press(3'b001);
    press(3'b001);
    rst = 1'b1;
    tick();
    check_out("rst_mid", 2'b00, 8'h00);
    set_keys(3'b001);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check_out("held_key", 2'b00, 8'h00);
    set_keys(3'b000);
    tick();
    tick();

    // Random traffic.
    for (int k = 0; k < 3; k++) rem[k] = 0;
    lv = 3'b000;
    for (int c = 0; c < 5000; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (rem[k] == 0) begin
          lv[k]  = ($urandom_range(0, 99) < ((k == 0) ? 12 : 35));
          rem[k] = int'($urandom_range(1, 6));
        end
        rem[k]--;
      end
      set_keys(lv);
      if ($urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 3) == 0)
          set_cur(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        else
          set_cur(int'($urandom_range(0, 2)), int'($urandom_range(0, 9)),
                  int'($urandom_range(0, 6)), int'($urandom_range(0, 9)));
      end
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
